// File: rtl/pcie_phy_pkg.sv
// Shared PHY symbol codes, framer state encoding and lane-replication helper.
package pcie_phy_pkg;

  // 8b/10b K-code symbols used by the transmit framer
  localparam logic [7:0] SYM_STP = 8'hFB;
  localparam logic [7:0] SYM_SDP = 8'h5C;
  localparam logic [7:0] SYM_END = 8'hFD;
  localparam logic [7:0] SYM_EDB = 8'hFE;
  localparam logic [7:0] SYM_COM = 8'hBC;
  localparam logic [7:0] SYM_SKP = 8'h1C;
  localparam logic [7:0] SYM_IDL = 8'h7C;

  // Widest link the replicate helper supports; callers truncate to their width
  localparam int unsigned MAX_LANES = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SOF  = 3'd1,
    ST_DATA = 3'd2,
    ST_EOF  = 3'd3,
    ST_NULL = 3'd4,
    ST_COM  = 3'd5,
    ST_SKP  = 3'd6
  } framer_state_t;

  // Copy one symbol onto every lane of a MAX_LANES-wide vector
  function automatic logic [8*MAX_LANES-1:0] replicate(input logic [7:0] sym);
    replicate = {MAX_LANES{sym}};
  endfunction

endpackage

// File: rtl/pcie_skp_timer.sv
// Free-running SKP interval timer; raises PEND once the interval elapses and
// holds it until the framer starts an ordered set (CLR).
module pcie_skp_timer #(
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned CNT_W        = 11
) (
  input  logic CLK,
  input  logic RESET_L,
  input  logic CLR,
  output logic PEND
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(SKP_INTERVAL - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_pend;

  // Count up to the interval end and saturate there; a clear always wins
  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      r_cnt  <= '0;
      r_pend <= 1'b0;
    end else if (CLR) begin
      r_cnt  <= '0;
      r_pend <= 1'b0;
    end else if (r_cnt == LP_LAST) begin
      r_pend <= 1'b1;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign PEND = r_pend;

endmodule

// File: rtl/pcie_tx_framer.sv
// PCIe transmit framer: wraps link-layer bytes in STP/SDP..END, fills gaps
// with IDL, nullifies underrun packets with EDB and inserts COM+SKP ordered
// sets at packet boundaries.
module pcie_tx_framer
  import pcie_phy_pkg::*;
#(
  parameter int unsigned LANES        = 1,
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned SKP_COUNT    = 3,
  parameter int unsigned CNT_W        = 11
) (
  input  logic                 CLK,
  input  logic                 RESET_L,
  input  logic [8*LANES-1:0]   IN_DATA,
  input  logic                 IN_VALID,
  input  logic                 IN_LAST,
  input  logic                 IN_DLLP,
  output logic                 IN_READY,
  output logic [8*LANES-1:0]   OUT_SYM,
  output logic [LANES-1:0]     OUT_K,
  output logic                 SKP_ACTIVE
);

  localparam int unsigned    LP_W        = 8 * LANES;
  localparam logic [2:0]     LP_SKP_LAST = 3'(SKP_COUNT - 1);

  framer_state_t     r_state;
  logic              r_dllp;
  logic [2:0]        r_skp_cnt;
  logic [LP_W-1:0]   r_sym;
  logic [LANES-1:0]  r_k;
  logic              r_skp_active;

  logic              w_skp_pend;
  logic              w_skp_clr;

  // Same control symbol on every lane
  function automatic logic [LP_W-1:0] rep(input logic [7:0] sym);
    rep = LP_W'(replicate(sym));
  endfunction

  assign w_skp_clr = (r_state == ST_COM);

  pcie_skp_timer #(
    .SKP_INTERVAL (SKP_INTERVAL),
    .CNT_W        (CNT_W)
  ) u_skp_timer (
    .CLK     (CLK),
    .RESET_L (RESET_L),
    .CLR     (w_skp_clr),
    .PEND    (w_skp_pend)
  );

  // Framer FSM; each state's symbol appears on OUT_SYM the following cycle
  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      r_state      <= ST_IDLE;
      r_dllp       <= 1'b0;
      r_skp_cnt    <= 3'd0;
      r_sym        <= rep(SYM_IDL);
      r_k          <= {LANES{1'b1}};
      r_skp_active <= 1'b0;
    end else begin
      r_sym        <= rep(SYM_IDL);
      r_k          <= {LANES{1'b1}};
      r_skp_active <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_skp_pend) begin
            r_state <= ST_COM;
          end else if (IN_VALID) begin
            r_state <= ST_SOF;
            r_dllp  <= IN_DLLP;
          end
        end
        ST_SOF: begin
          r_sym   <= r_dllp ? rep(SYM_SDP) : rep(SYM_STP);
          r_state <= ST_DATA;
        end
        ST_DATA: begin
          r_sym <= IN_DATA;
          r_k   <= {LANES{1'b0}};
          if (IN_VALID) begin
            if (IN_LAST) r_state <= ST_EOF;
          end else begin
            r_state <= ST_NULL;
          end
        end
        ST_EOF: begin
          r_sym <= rep(SYM_END);
          if (w_skp_pend) begin
            r_state <= ST_COM;
          end else if (IN_VALID) begin
            r_state <= ST_SOF;
            r_dllp  <= IN_DLLP;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_NULL: begin
          r_sym   <= rep(SYM_EDB);
          r_state <= w_skp_pend ? ST_COM : ST_IDLE;
        end
        ST_COM: begin
          r_sym        <= rep(SYM_COM);
          r_skp_active <= 1'b1;
          r_skp_cnt    <= 3'd0;
          r_state      <= ST_SKP;
        end
        ST_SKP: begin
          r_sym        <= rep(SYM_SKP);
          r_skp_active <= 1'b1;
          if (r_skp_cnt == LP_SKP_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_skp_cnt <= r_skp_cnt + 3'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign IN_READY   = (r_state == ST_DATA);
  assign OUT_SYM    = r_sym;
  assign OUT_K      = r_k;
  assign SKP_ACTIVE = r_skp_active;

endmodule

// File: tb/tb_pcie_tx_framer.sv
// Scoreboard bench for pcie_tx_framer: a 1-lane instance with the default
// SKP interval and a 4-lane instance with a 16-cycle SKP interval.
module tb_pcie_tx_framer;

  localparam logic [7:0] STP = 8'hFB;
  localparam logic [7:0] SDP = 8'h5C;
  localparam logic [7:0] ENDS = 8'hFD;
  localparam logic [7:0] EDB = 8'hFE;
  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] SKP = 8'h1C;
  localparam logic [7:0] IDL = 8'h7C;

  typedef struct {
    logic [31:0] sym;
    logic [3:0]  k;
    logic        skp;
    logic        rdy;
    string       tag;
  } exp_t;

  logic clk;

  logic        rst_a, a_v, a_last, a_dllp, a_rdy, a_skp;
  logic [7:0]  a_d, a_sym;
  logic [0:0]  a_k;

  logic        rst_b, b_v, b_last, b_dllp, b_rdy, b_skp;
  logic [31:0] b_d, b_sym;
  logic [3:0]  b_k;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  pcie_tx_framer #(
    .LANES(1), .SKP_INTERVAL(1180), .SKP_COUNT(3), .CNT_W(11)
  ) dut_a (
    .CLK(clk), .RESET_L(rst_a), .IN_DATA(a_d), .IN_VALID(a_v), .IN_LAST(a_last),
    .IN_DLLP(a_dllp), .IN_READY(a_rdy), .OUT_SYM(a_sym), .OUT_K(a_k), .SKP_ACTIVE(a_skp)
  );

  pcie_tx_framer #(
    .LANES(4), .SKP_INTERVAL(16), .SKP_COUNT(3), .CNT_W(4)
  ) dut_b (
    .CLK(clk), .RESET_L(rst_b), .IN_DATA(b_d), .IN_VALID(b_v), .IN_LAST(b_last),
    .IN_DLLP(b_dllp), .IN_READY(b_rdy), .OUT_SYM(b_sym), .OUT_K(b_k), .SKP_ACTIVE(b_skp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rep4(input logic [7:0] s);
    rep4 = {4{s}};
  endfunction

  // Drive one cycle of inputs and queue the outputs expected after the next edge
  task automatic step(input bit sel, input logic rst, input logic v, input logic last,
                      input logic dllp, input logic [31:0] d, input logic [31:0] es,
                      input logic [3:0] ek, input logic eskp, input logic erdy,
                      input string tag);
    exp_t e;
    @(negedge clk);
    #1;
    e.sym = es; e.k = ek; e.skp = eskp; e.rdy = erdy; e.tag = tag;
    if (!sel) begin
      rst_a = rst; a_v = v; a_last = last; a_dllp = dllp; a_d = d[7:0];
      q_a.push_back(e);
    end else begin
      rst_b = rst; b_v = v; b_last = last; b_dllp = dllp; b_d = d;
      q_b.push_back(e);
    end
  endtask

  task automatic ctl(input bit sel, input logic rst, input logic v, input logic last,
                     input logic dllp, input logic [31:0] d, input logic [7:0] s,
                     input logic eskp, input logic erdy, input string tag);
    step(sel, rst, v, last, dllp, d, rep4(s), 4'hF, eskp, erdy, tag);
  endtask

  task automatic dat(input bit sel, input logic v, input logic last, input logic dllp,
                     input logic [31:0] d, input logic erdy, input string tag);
    step(sel, 1'b1, v, last, dllp, d, d, 4'h0, 1'b0, erdy, tag);
  endtask

  task automatic idles(input bit sel, input int n, input string tag);
    repeat (n) ctl(sel, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, IDL, 1'b0, 1'b0, tag);
  endtask

  task automatic skpset(input bit sel, input logic v, input string tag);
    ctl(sel, 1'b1, v, 1'b0, 1'b0, 32'h0, COM, 1'b1, 1'b0, tag);
    repeat (3) ctl(sel, 1'b1, v, 1'b0, 1'b0, 32'h0, SKP, 1'b1, 1'b0, tag);
  endtask

  // Monitor: every queued expectation is checked against the DUT mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      n_checks++;
      if (a_sym === e.sym[7:0] && a_k === e.k[0:0] && a_skp === e.skp && a_rdy === e.rdy)
        n_pass++;
      else
        $display("FAIL %s: got sym=%h k=%b skp=%b rdy=%b, expected sym=%h k=%b skp=%b rdy=%b",
                 e.tag, a_sym, a_k, a_skp, a_rdy, e.sym[7:0], e.k[0], e.skp, e.rdy);
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      n_checks++;
      if (b_sym === e.sym && b_k === e.k && b_skp === e.skp && b_rdy === e.rdy)
        n_pass++;
      else
        $display("FAIL %s: got sym=%h k=%h skp=%b rdy=%b, expected sym=%h k=%h skp=%b rdy=%b",
                 e.tag, b_sym, b_k, b_skp, b_rdy, e.sym, e.k, e.skp, e.rdy);
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b0; a_v = 1'b0; a_last = 1'b0; a_dllp = 1'b0; a_d = 8'h0;
    rst_b = 1'b0; b_v = 1'b0; b_last = 1'b0; b_dllp = 1'b0; b_d = 32'h0;

    // ---- 1-lane instance ----
    ctl(0, 0, 0, 0, 0, 32'h0, IDL, 0, 0, "rst_a0");
    ctl(0, 0, 0, 0, 0, 32'h0, IDL, 0, 0, "rst_a1");

    // three-beat TLP, IN_VALID continuous
    ctl(0, 1, 1, 0, 0, 32'h11, IDL, 0, 0, "t1_idle");
    ctl(0, 1, 1, 0, 0, 32'h11, STP, 0, 1, "t1_stp");
    dat(0, 1, 0, 0, 32'h11, 1, "t1_d0");
    dat(0, 1, 0, 0, 32'h22, 1, "t1_d1");
    dat(0, 1, 1, 0, 32'h33, 0, "t1_d2");
    ctl(0, 1, 0, 0, 0, 32'h0, ENDS, 0, 0, "t1_end");
    ctl(0, 1, 0, 0, 0, 32'h0, IDL, 0, 0, "t1_gap");

    // underrun after the first beat: DATA echoes the idle bus, then EDB
    ctl(0, 1, 1, 0, 0, 32'hA1, IDL, 0, 0, "t3_idle");
    ctl(0, 1, 1, 0, 0, 32'hA1, STP, 0, 1, "t3_stp");
    dat(0, 1, 0, 0, 32'hA1, 1, "t3_d0");
    step(0, 1, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, "t3_drop");
    ctl(0, 1, 0, 0, 0, 32'h0, EDB, 0, 0, "t3_edb");
    ctl(0, 1, 0, 0, 0, 32'h0, IDL, 0, 0, "t3_idl");

    // back-to-back TLP then DLLP with IN_VALID held: END directly followed by SDP
    ctl(0, 1, 1, 1, 0, 32'hB1, IDL, 0, 0, "t5_idle");
    ctl(0, 1, 1, 1, 0, 32'hB1, STP, 0, 1, "t5_stp");
    dat(0, 1, 1, 0, 32'hB1, 0, "t5_p0");
    ctl(0, 1, 1, 0, 1, 32'hC1, ENDS, 0, 0, "t5_end0");
    ctl(0, 1, 1, 0, 0, 32'hC1, SDP, 0, 1, "t5_sdp");
    dat(0, 1, 0, 0, 32'hC1, 1, "t5_p1a");
    dat(0, 1, 1, 0, 32'hC2, 0, "t5_p1b");
    ctl(0, 1, 0, 0, 0, 32'h0, ENDS, 0, 0, "t5_end1");
    ctl(0, 1, 0, 0, 0, 32'h0, IDL, 0, 0, "t5_idl");

    // ---- 4-lane instance, SKP interval 16 ----
    ctl(1, 0, 0, 0, 0, 32'h0, IDL, 0, 0, "rst_b");

    // single-beat DLLP
    ctl(1, 1, 1, 1, 1, 32'h44332211, IDL, 0, 0, "t2_idle");
    ctl(1, 1, 1, 1, 1, 32'h44332211, SDP, 0, 1, "t2_sdp");
    dat(1, 1, 1, 1, 32'h44332211, 0, "t2_d");
    ctl(1, 1, 0, 0, 0, 32'h0, ENDS, 0, 0, "t2_end");

    // packet straddles timer expiry; ordered set waits for END
    idles(1, 5, "t4_pre");
    ctl(1, 1, 1, 0, 0, 32'h10203040, IDL, 0, 0, "t4_idle");
    ctl(1, 1, 1, 0, 0, 32'h10203040, STP, 0, 1, "t4_stp");
    for (int k = 0; k < 6; k++) dat(1, 1, 0, 0, 32'h10203040 + 32'(k), 1, "t4_d");
    dat(1, 1, 1, 0, 32'h10203046, 0, "t4_dl");
    ctl(1, 1, 0, 0, 0, 32'h0, ENDS, 0, 0, "t4_end");
    skpset(1, 0, "t4_skp");
    ctl(1, 1, 0, 0, 0, 32'h0, IDL, 0, 0, "t4_idl");

    // pending SKP in IDLE wins over a waiting IN_VALID
    idles(1, 12, "t5b_wait");
    ctl(1, 1, 1, 1, 0, 32'hE1E1E1E1, IDL, 0, 0, "t5b_pri");
    skpset(1, 1, "t5b_skp");
    ctl(1, 1, 1, 1, 0, 32'hE1E1E1E1, IDL, 0, 0, "t5b_sof");
    ctl(1, 1, 1, 1, 0, 32'hE1E1E1E1, STP, 0, 1, "t5b_stp");
    dat(1, 1, 1, 0, 32'hE1E1E1E1, 0, "t5b_d");
    ctl(1, 1, 0, 0, 0, 32'h0, ENDS, 0, 0, "t5b_end");

    // reset mid-packet: no END/EDB, and the SKP timer restarts from zero
    ctl(1, 1, 1, 0, 0, 32'hF1F2F3F4, IDL, 0, 0, "t6_idle");
    ctl(1, 1, 1, 0, 0, 32'hF1F2F3F4, STP, 0, 1, "t6_stp");
    dat(1, 1, 0, 0, 32'hF1F2F3F4, 1, "t6_d");
    ctl(1, 0, 1, 0, 0, 32'hF5F6F7F8, IDL, 0, 0, "t6_rst");
    idles(1, 17, "t6_cnt");
    skpset(1, 0, "t6_skp");
    ctl(1, 1, 0, 0, 0, 32'h0, IDL, 0, 0, "t6_idl");

    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (q_a.size() == 0 && q_b.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d/%0d entries left, expected 0/0", q_a.size(), q_b.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
